// File: rtl/pixel_unshift.sv
// Parallel-to-serial unloader for an 11-tap, 24-bit pixel window.
// Captures the window on load and streams the selected taps oldest-first on a valid/ready port.
module pixel_unshift (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] pix_0,
  input  logic [23:0] pix_1,
  input  logic [23:0] pix_2,
  input  logic [23:0] pix_3,
  input  logic [23:0] pix_4,
  input  logic [23:0] pix_5,
  input  logic [23:0] pix_6,
  input  logic [23:0] pix_7,
  input  logic [23:0] pix_8,
  input  logic [23:0] pix_9,
  input  logic [23:0] pix_10,
  input  logic [3:0]  len,
  input  logic        load,
  output logic        load_rdy,
  output logic [23:0] pixel,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        sob,
  output logic        eob,
  output logic        busy
);

  localparam int unsigned NTAPS = 11;
  localparam int unsigned PIX_W = 24;
  localparam int unsigned IDX_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [PIX_W-1:0]   cap_q [NTAPS];
  logic [PIX_W-1:0]   cap_d [NTAPS];
  logic [PIX_W-1:0]   pix_in [NTAPS];
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [PIX_W-1:0]   pixel_d;
  logic               valid_d, sob_d, eob_d, load_rdy_d, busy_d;
  logic [IDX_W-1:0]   len_eff;
  logic [IDX_W-1:0]   first_idx;
  logic [IDX_W-1:0]   next_idx;
  logic [PIX_W-1:0]   first_pix;
  logic [PIX_W-1:0]   next_pix;

  assign pix_in[0]  = pix_0;
  assign pix_in[1]  = pix_1;
  assign pix_in[2]  = pix_2;
  assign pix_in[3]  = pix_3;
  assign pix_in[4]  = pix_4;
  assign pix_in[5]  = pix_5;
  assign pix_in[6]  = pix_6;
  assign pix_in[7]  = pix_7;
  assign pix_in[8]  = pix_8;
  assign pix_in[9]  = pix_9;
  assign pix_in[10] = pix_10;

  // Out-of-range lengths fall back to the full window.
  assign len_eff   = (len == '0 || len > IDX_W'(NTAPS)) ? IDX_W'(NTAPS) : len;
  assign first_idx = IDX_W'(len_eff - IDX_W'(1));
  assign next_idx  = IDX_W'(idx_q - IDX_W'(1));

  // Tap select by index; indices beyond the window decode to zero.
  always_comb begin
    first_pix = '0;
    next_pix  = '0;
    for (int k = 0; k < NTAPS; k++) begin
      if (first_idx == IDX_W'(k)) first_pix = pix_in[k];
      if (next_idx  == IDX_W'(k)) next_pix  = cap_q[k];
    end
  end

  always_comb begin
    state_d    = state_q;
    cap_d      = cap_q;
    idx_d      = idx_q;
    pixel_d    = pixel;
    valid_d    = out_valid;
    sob_d      = sob;
    eob_d      = eob;
    load_rdy_d = load_rdy;
    busy_d     = busy;

    case (state_q)
      IDLE: begin
        if (load) begin
          cap_d      = pix_in;
          idx_d      = first_idx;
          pixel_d    = first_pix;
          valid_d    = 1'b1;
          sob_d      = 1'b1;
          eob_d      = (len_eff == IDX_W'(1));
          load_rdy_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (out_valid && out_ready) begin
          if (idx_q != '0) begin
            idx_d   = next_idx;
            pixel_d = next_pix;
            sob_d   = 1'b0;
            eob_d   = (idx_q == IDX_W'(1));
          end else begin
            valid_d    = 1'b0;
            sob_d      = 1'b0;
            eob_d      = 1'b0;
            load_rdy_d = 1'b1;
            busy_d     = 1'b0;
            state_d    = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      pixel     <= '0;
      out_valid <= 1'b0;
      sob       <= 1'b0;
      eob       <= 1'b0;
      load_rdy  <= 1'b1;
      busy      <= 1'b0;
      for (int k = 0; k < NTAPS; k++) cap_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pixel     <= pixel_d;
      out_valid <= valid_d;
      sob       <= sob_d;
      eob       <= eob_d;
      load_rdy  <= load_rdy_d;
      busy      <= busy_d;
      for (int k = 0; k < NTAPS; k++) cap_q[k] <= cap_d[k];
    end
  end

endmodule

// File: tb/tb_pixel_unshift.sv
// Directed and randomized bench for pixel_unshift against a queue-based burst model.
module tb_pixel_unshift;

  logic        clk;
  logic        rst;
  logic [23:0] pix [11];
  logic [3:0]  len;
  logic        load;
  logic        load_rdy;
  logic [23:0] pixel;
  logic        out_valid;
  logic        out_ready;
  logic        sob;
  logic        eob;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  logic [23:0] exp_q [$];

  pixel_unshift dut (
    .clk(clk), .rst(rst),
    .pix_0(pix[0]), .pix_1(pix[1]), .pix_2(pix[2]), .pix_3(pix[3]),
    .pix_4(pix[4]), .pix_5(pix[5]), .pix_6(pix[6]), .pix_7(pix[7]),
    .pix_8(pix[8]), .pix_9(pix[9]), .pix_10(pix[10]),
    .len(len), .load(load), .load_rdy(load_rdy), .pixel(pixel),
    .out_valid(out_valid), .out_ready(out_ready), .sob(sob), .eob(eob), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_pixel"}, 32'(pixel), 32'd0);
    check({tag, "_sob"}, 32'(sob), 32'd0);
    check({tag, "_eob"}, 32'(eob), 32'd0);
    check({tag, "_load_rdy"}, 32'(load_rdy), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // mode 0: ready always high; 1: fixed backpressure pattern; 2: random ready.
  task automatic run_burst(input logic [23:0] win [11], input logic [3:0] l, input int mode,
                           input bit disturb, input int abort_after);
    int  eff;
    int  beat;
    int  step;
    bit  v;
    bit  rdy;
    bit  done;
    bit  pat [7];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    @(negedge clk);
    check("pre_load_rdy", 32'(load_rdy), 32'd1);
    check("pre_valid", 32'(out_valid), 32'd0);
    pix = win;
    len = l;
    load = 1'b1;
    out_ready = 1'($urandom % 2);
    eff = (l == 0 || l > 11) ? 11 : int'(l);
    exp_q.delete();
    for (int i = eff - 1; i >= 0; i--) exp_q.push_back(win[i]);

    @(negedge clk);
    load = 1'b0;
    beat = 0;
    step = 0;
    done = 1'b0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      v = (exp_q.size() > 0);
      check("out_valid", 32'(out_valid), 32'(v));
      check("load_rdy", 32'(load_rdy), 32'(!v));
      check("busy", 32'(busy), 32'(v));
      if (!v) begin
        done = 1'b1;
        break;
      end
      check("pixel", 32'(pixel), 32'(exp_q[0]));
      check("sob", 32'(sob), 32'(beat == 0));
      check("eob", 32'(eob), 32'(exp_q.size() == 1));
      if (abort_after >= 0 && beat == abort_after) begin
        #1 rst = 1'b1;
        #1 check_reset_outputs("midburst_rst");
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        done = 1'b1;
        break;
      end
      if (mode == 0)      rdy = 1'b1;
      else if (mode == 1) rdy = (step < 7) ? pat[step] : 1'b1;
      else                rdy = ($urandom % 4) != 0;
      out_ready = rdy;
      step++;
      if (disturb) begin
        for (int k = 0; k < 11; k++) pix[k] = 24'($urandom);
        load = 1'($urandom % 2);
      end
      if (rdy) begin
        void'(exp_q.pop_front());
        beat++;
      end
      @(negedge clk);
    end
    check("burst_done", 32'(done), 32'd1);
    load = 1'b0;
  endtask

  logic [23:0] ramp [11];
  logic [23:0] rwin [11];

  initial begin
    rst = 1'b0;
    load = 1'b0;
    out_ready = 1'b0;
    len = 4'd0;
    for (int k = 0; k < 11; k++) begin
      pix[k] = 24'd0;
      ramp[k] = 24'(k);
    end

    // Power-on reset.
    #1 rst = 1'b1;
    #1 check_reset_outputs("por");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_valid", 32'(out_valid), 32'd0);
      check("idle_load_rdy", 32'(load_rdy), 32'd1);
    end

    run_burst(ramp, 4'd11, 0, 1'b0, -1);
    run_burst(ramp, 4'd3, 0, 1'b0, -1);
    run_burst(ramp, 4'd0, 0, 1'b0, -1);
    run_burst(ramp, 4'd15, 0, 1'b0, -1);
    run_burst(ramp, 4'd4, 1, 1'b0, -1);

    for (int k = 0; k < 11; k++) rwin[k] = 24'($urandom);
    run_burst(rwin, 4'd11, 2, 1'b1, -1);
    for (int k = 0; k < 11; k++) rwin[k] = 24'($urandom);
    run_burst(rwin, 4'd1, 0, 1'b1, -1);

    // Asynchronous reset in the middle of an idle cycle.
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("post_rst_valid", 32'(out_valid), 32'd0);
      check("post_rst_load_rdy", 32'(load_rdy), 32'd1);
    end

    for (int k = 0; k < 11; k++) rwin[k] = 24'($urandom);
    run_burst(rwin, 4'd11, 0, 1'b0, 2);
    run_burst(ramp, 4'd2, 0, 1'b0, -1);

    for (int b = 0; b < 20; b++) begin
      for (int k = 0; k < 11; k++) rwin[k] = 24'($urandom);
      run_burst(rwin, 4'($urandom % 16), 2, 1'($urandom % 2), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pixel_unshift.md
# pixel_unshift

Parallel-to-serial pixel unloader, the transmit end of the 11-tap pixel shift register interface. It captures an 11-pixel window, 24-bit RGB per tap, in one cycle. It then emits a programmable number of those pixels one per transfer on a valid/ready stream, oldest tap first. A downstream shift register fed from this stream therefore rebuilds the same tap ordering.

## Interface
Parameters:
- none; tap count fixed at 11, pixel width fixed at 24.

Ports:
- clk  in  1  single clock; all state updates on posedge clk.
- rst  in  1  reset, asynchronous, active-high.
- pix_0 … pix_10  in  24 each  parallel window taps.
  - pix_0 is the newest pixel; pix_10 is the oldest.
- len  in  4  number of pixels to emit. Sampled at load.
  - 1..11 are legal.
  - 0 or 12..15 are treated as 11.
- load  in  1  load request. Accepted only when load_rdy=1.
- load_rdy  out  1  high when idle and able to accept a load.
- pixel  out  24  current output pixel. Registered.
- out_valid  out  1  pixel is valid. Registered.
- out_ready  in  1  downstream accepts pixel this cycle.
- sob  out  1  start of burst: first pixel of a burst. Registered, qualified by out_valid.
- eob  out  1  end of burst: last pixel of a burst. Registered, qualified by out_valid.
- busy  out  1  burst in progress; equals ~load_rdy.

## Operation
- Two states: IDLE and SEND.
- Effective length L = (len==0 || len>11) ? 11 : len.
- Emit order within a burst: pix_{L-1}, pix_{L-2}, …, pix_0.
  - Oldest selected tap goes first; pix_0 always goes last.
- IDLE:
  - load_rdy=1, out_valid=0.
  - On load=1, capture all 11 taps and L into internal registers.
  - Set the index counter to L-1.
  - Drive pixel=pix_{L-1}, out_valid=1, sob=1, eob=(L==1).
  - Go to SEND.
- SEND:
  - load is ignored and pix_* changes are ignored; the captured copy is used.
  - Handshake: a transfer occurs on an edge where out_valid=1 and out_ready=1.
  - On a transfer with index>0:
    - decrement the index;
    - pixel becomes the next captured tap;
    - sob=0;
    - eob=(new index==0).
  - On a transfer with index==0 (eob=1): out_valid=0, sob=0, eob=0; go to IDLE.
- Stall rule: while out_valid=1 and out_ready=0, pixel, sob and eob hold stable. out_valid never drops without a transfer.
- Reset, including mid-burst:
  - state=IDLE, load_rdy=1, busy=0;
  - out_valid=0, pixel=24'h0, sob=0, eob=0;
  - index=0;
  - any remaining pixels of the burst are discarded.
- pixel holds its last value after the burst ends. It is don't-care while out_valid=0.

## Timing
- Load latency: load accepted at edge N gives out_valid=1 and the first pixel from edge N, visible in cycle N+1.
- Throughput with out_ready held high:
  - L transfers over edges N+1 … N+L;
  - load_rdy=1 again after edge N+L;
  - next load is accepted no earlier than edge N+L+1.
  - Net rate is L pixels per L+1 cycles; one bubble between bursts.
- load_rdy, busy and out_valid are decoded from or held in registers. There is no combinational path from out_ready or load to any output.
- L=1: a single beat with sob=1 and eob=1 on the same cycle.
- load and out_ready arriving together in IDLE: load is taken. out_valid is 0 in that cycle, so out_ready has no effect.

## Test plan
- Reset and idle check:
  - Stimulus: reset asserted mid-cycle.
  - Required response, immediately and asynchronously: out_valid=0, pixel=0, sob=0, eob=0, load_rdy=1.
  - Required response after release: state stays idle with load=0.
- Full burst:
  - Stimulus: pix_k=24'h0000_0k (pix_10=24'h00000A), len=11, out_ready=1.
  - Required response: pixels 0A,09,…,00 on 11 consecutive cycles starting one cycle after load.
  - sob on 0A only, eob on 00 only; load_rdy returns one cycle after the 00 beat.
- Short burst and length clamp:
  - Stimulus: len=3.
  - Required response: pixels 02,01,00 with sob/eob on the first and last beat.
  - Repeat with len=0 and with len=15: 11 beats each time.
- Backpressure:
  - Stimulus: len=4, out_ready toggling 1,0,0,1,0,1,1.
  - Required response: pixel, sob and eob stable across each stall.
  - Exactly 4 transfers, order 03,02,01,00, no duplicates or drops.
- Input isolation and ignored load:
  - Stimulus: change pix_* and pulse load during SEND.
  - Required response: emitted data equals the values captured at load, and no new burst starts.
  - Single-beat case: len=1 gives one beat with sob=eob=1.
- Reset mid-burst:
  - Stimulus: assert rst after 2 of 11 transfers.
  - Required response: out_valid=0 immediately.
  - After release, a new load with len=2 emits 01,00 cleanly with sob and eob correct.
